// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
// Captures a 20-bit unsigned ALU result on a start pulse and converts it to six
// BCD digits with an iterative double-dabble engine (one shift per clock). The
// six active-low seven-segment displays are updated together and then held
// until the next conversion completes. Values above 999999 show dashes and
// raise overflow.
//
// Optional feature: define RESULT_DISPLAY_LZB_EN for leading-zero blanking.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start_i     conversion request, ignored while busy_o is high
//   value_i     unsigned value, sampled when start_i is accepted
//   busy_o      conversion in progress
//   done_o      one-cycle pulse when the displays update
//   overflow_o  the last accepted value exceeded 999999
//   hex0_o..hex5_o  active-low segments, bit0=a .. bit6=g, hex0 = LS digit
// -----------------------------------------------------------------------------
module result_display (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [19:0] value_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        overflow_o,
   output logic [6:0]  hex0_o,
   output logic [6:0]  hex1_o,
   output logic [6:0]  hex2_o,
   output logic [6:0]  hex3_o,
   output logic [6:0]  hex4_o,
   output logic [6:0]  hex5_o
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_UPDATE  = 2'd2
   } state_e;

   state_e          state_q;
   logic [19:0]     bin_q;
   logic [23:0]     bcd_q;
   logic [4:0]      step_q;
   logic            ovf_pend_q;
   logic            busy_q;
   logic            done_q;
   logic            overflow_q;
   logic [5:0][6:0] hex_q;

   logic [23:0]     bcd_adj_s;
   logic [23:0]     bcd_d;
   logic [19:0]     bin_d;
   logic [5:0][6:0] seg_s;
   logic            lead_s;

   // Decimal digit to active-low segment pattern (g..a).
   function automatic logic [6:0] seg_f(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_adj_s = bcd_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end else begin
            bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
         end
      end
      bcd_d = {bcd_adj_s[22:0], bin_q[19]};
      bin_d = {bin_q[18:0], 1'b0};
   end

   // Segment encodings of the finished BCD digits, with optional leading-zero blanking.
   always_comb begin
      seg_s  = {6{SEG_BLANK}};
      lead_s = 1'b1;
      for (int i = 5; i >= 0; i--) begin
`ifdef RESULT_DISPLAY_LZB_EN
         // hex0 never blanks, so zero still shows a single "0".
         if ((i != 0) && lead_s && (bcd_q[4*i +: 4] == 4'd0)) begin
            seg_s[i] = SEG_BLANK;
         end else begin
            seg_s[i] = seg_f(bcd_q[4*i +: 4]);
            lead_s   = 1'b0;
         end
`else
         seg_s[i] = seg_f(bcd_q[4*i +: 4]);
         lead_s   = 1'b0;
`endif
      end
   end

   // Control FSM, conversion datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bin_q      <= 20'd0;
         bcd_q      <= 24'd0;
         step_q     <= 5'd0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         hex_q      <= {6{SEG_BLANK}};
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  bin_q      <= value_i;
                  bcd_q      <= 24'd0;
                  step_q     <= 5'd0;
                  ovf_pend_q <= (value_i > 20'd999999);
                  busy_q     <= 1'b1;
                  state_q    <= ST_CONVERT;
               end else begin
                  state_q    <= ST_IDLE;
               end
            end
            ST_CONVERT: begin
               bcd_q      <= bcd_d;
               bin_q      <= bin_d;
               // A carry out of the top digit also means the value does not fit.
               ovf_pend_q <= ovf_pend_q | bcd_adj_s[23];
               step_q     <= step_q + 5'd1;
               if (step_q == 5'd19) begin
                  state_q <= ST_UPDATE;
               end else begin
                  state_q <= ST_CONVERT;
               end
            end
            ST_UPDATE: begin
               for (int i = 0; i < 6; i++) begin
                  hex_q[i] <= ovf_pend_q ? SEG_DASH : seg_s[i];
               end
               overflow_q <= ovf_pend_q;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign overflow_o = overflow_q;
   assign hex0_o     = hex_q[0];
   assign hex1_o     = hex_q[1];
   assign hex2_o     = hex_q[2];
   assign hex3_o     = hex_q[3];
   assign hex4_o     = hex_q[4];
   assign hex5_o     = hex_q[5];

endmodule

// File: doc/result_display.md
# result_display

Sequential binary-to-decimal display stage that sits directly downstream of the lab ALU. It captures the ALU's 20-bit unsigned result on a start pulse and converts it to six BCD digits with an iterative double-dabble engine, one shift per clock. It then drives six active-low seven-segment displays (HEX5..HEX0) and holds them until the next conversion completes.

## Interface
- WIDTH, 20: input value width; fixed to the ALU result width.
- DIGITS, 6: number of BCD digits and displays; fixed at 6.
- clk  input  1  system clock (50 MHz board clock).
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a conversion; sampled on rising `clk`.
- value  input  20  unsigned ALU result, sampled in the same cycle `start` is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the displays update.
- overflow  output  1  the last accepted value exceeded 999999.
- hex0..hex5  output  7 each  segments, active-low, bit0=a .. bit6=g; hex0 is the least-significant digit.

## Operation
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE: if `start`=1, latch `value` into the shift register, clear the 24-bit BCD accumulator, set the step counter to 0, latch `value > 999999` into the pending-overflow register, and go to CONVERT.
- CONVERT, one step per cycle:
  - For each 4-bit BCD nibble ≥5, add 3.
  - Then shift {bcd, bin} left by 1.
  - After step 19 (20 steps total), go to UPDATE.
- UPDATE:
  - Register the six digit encodings into hex0..hex5 and the pending overflow into `overflow`.
  - Assert `done` for this single cycle, then return to IDLE.
- `start` is ignored while `busy`=1; no queuing.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
- Overflow (value > 999999, i.e. 1000000..1048575): all six displays show dash and `overflow`=1. BCD digits are discarded.
- Outputs hold their last registered values between conversions.

## Timing
- Reset values (asynchronous, applied while `rst_n`=0):
  - state=IDLE, busy=0, done=0, overflow=0.
  - hex0..hex5=1111111 (blank); internal registers all 0.
- Accept edge E0: `start`=1 while in IDLE; `busy`=1 from the cycle after E0.
- Edges E1..E20 perform the 20 conversion steps.
- Edge E21:
  - hex outputs and `overflow` update.
  - `done`=1 during the cycle after E21.
  - `busy`=0 in the cycle after E21; state is IDLE in that cycle.
- Latency from the accept edge to display update is 21 clocks. Minimum start-to-start interval is 22 clocks.
- `start` high during the `done` cycle is accepted at that edge (back-to-back conversions).
- Reset mid-conversion aborts immediately: displays blank, and no `done` is produced for the aborted request.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: RESULT_DISPLAY_LZB_EN (leading-zero blanking).
- Defined:
  - After UPDATE, every zero digit more significant than the highest non-zero digit shows blank.
  - hex0 always shows a digit, so value 0 displays a single "0".
  - Overflow dashes are never blanked.
- Undefined: all six digits are always displayed, including leading zeros.

## Test plan
- Basic conversion: reset; `start` with value=123456.
  - 21 clocks later `done`=1.
  - hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010.
  - `overflow`=0.
- Maximum in-range value and ALU maximum:
  - value=999999 → all hex = 0010000.
  - Then value=491520 (15<<15) → digits 4,9,1,5,2,0.
- Zero and macro:
  - value=0 with RESULT_DISPLAY_LZB_EN → hex0=1000000, hex1..hex5=1111111.
  - Without the macro → all hex=1000000.
- Overflow:
  - value=1000000 → all hex=0111111, `overflow`=1.
  - Next value=7 → `overflow`=0, hex0=1111000.
- Busy rules:
  - `start` re-pulsed with value=5 at E5 of a conversion of 42 → ignored; result shows 42; exactly one `done`.
  - `start` held high in the `done` cycle with value=8 → accepted; second `done` arrives 22 clocks after the first.
- Reset mid-operation:
  - Assert `rst_n`=0 at E10 of a conversion of 654321 → hex all blank, `busy`=0, no `done`.
  - After release, conversion of 11 completes normally.
